// File: rtl/isp_awb_gain.sv
// isp_awb_gain: per-channel white-balance gain stage with frame statistics.
//
// Sits behind the debayer. Applies fixed-point gains (GAIN_FRAC fractional
// bits) with round-half-up and saturation through a 3-stage pipeline. Gain
// writes are shadowed and only become active at a frame start (rising edge
// of in_vsync). Pre-gain R/G/B sums and a pixel count are accumulated per
// frame and published on stat_* with a one-cycle stat_valid at frame start.
//
// Optional build macro: AWB_STAT_WINDOW_EN restricts statistics to an
// inclusive window given by win_x0/win_x1/win_y0/win_y1 (sampled at frame
// start). The gain path is identical in both builds.
//
// Ports:
//   pclk, rst                  clock, synchronous active-high reset
//   in_href/in_vsync/in_de     timing from debayer
//   in_r/in_g/in_b             input pixel
//   gain_r/gain_g/gain_b       requested gains, captured by gain_wr
//   gain_wr                    one-cycle gain capture strobe
//   win_x0/x1/y0/y1            statistics window (AWB_STAT_WINDOW_EN only)
//   out_href/out_vsync/out_de  timing delayed by 3 cycles
//   out_r/out_g/out_b          gained pixel, 0 while out_href is low
//   stat_sum_r/g/b, stat_cnt   previous-frame statistics
//   stat_valid                 one-cycle pulse when stat_* update
module isp_awb_gain #(
    parameter int unsigned BITS      = 8,
    parameter int unsigned GAIN_BITS = 10,
    parameter int unsigned GAIN_FRAC = 8,
    parameter int unsigned SUM_BITS  = 32,
    parameter int unsigned WIDTH     = 1280,
    parameter int unsigned HEIGHT    = 960
) (
    input  logic                 pclk,
    input  logic                 rst,
    input  logic                 in_href,
    input  logic                 in_vsync,
    input  logic                 in_de,
    input  logic [BITS-1:0]      in_r,
    input  logic [BITS-1:0]      in_g,
    input  logic [BITS-1:0]      in_b,
    input  logic [GAIN_BITS-1:0] gain_r,
    input  logic [GAIN_BITS-1:0] gain_g,
    input  logic [GAIN_BITS-1:0] gain_b,
    input  logic                 gain_wr,
`ifdef AWB_STAT_WINDOW_EN
    input  logic [15:0]          win_x0,
    input  logic [15:0]          win_x1,
    input  logic [15:0]          win_y0,
    input  logic [15:0]          win_y1,
`endif
    output logic                 out_href,
    output logic                 out_vsync,
    output logic                 out_de,
    output logic [BITS-1:0]      out_r,
    output logic [BITS-1:0]      out_g,
    output logic [BITS-1:0]      out_b,
    output logic [SUM_BITS-1:0]  stat_sum_r,
    output logic [SUM_BITS-1:0]  stat_sum_g,
    output logic [SUM_BITS-1:0]  stat_sum_b,
    output logic [SUM_BITS-1:0]  stat_cnt,
    output logic                 stat_valid
);

    localparam int unsigned PROD_W = BITS + GAIN_BITS;
    localparam int unsigned RND_W  = PROD_W + 1;
    localparam int unsigned SHR_W  = RND_W - GAIN_FRAC;
    localparam int unsigned ACC_W  = SUM_BITS + 1;

    localparam logic [GAIN_BITS-1:0] GAIN_ONE = GAIN_BITS'(1 << GAIN_FRAC);
    localparam logic [RND_W-1:0]     RND_HALF = RND_W'(1 << (GAIN_FRAC - 1));
    localparam logic [SHR_W-1:0]     PIX_MAX  = SHR_W'((1 << BITS) - 1);

    // Geometry must fit the 16-bit window counters.
    if (WIDTH == 0 || WIDTH > 65536 || HEIGHT == 0 || HEIGHT > 65536 ||
        GAIN_FRAC == 0 || SUM_BITS < BITS) begin : g_param_check
        $error("isp_awb_gain: unsupported parameter set");
    end

    // Channel index: 2 = R, 1 = G, 0 = B.
    logic [2:0][BITS-1:0]      w_in_pix;
    logic [2:0][GAIN_BITS-1:0] w_gain_in;
    logic                      w_fs;
    logic                      w_in_win;
    logic                      w_pix_ok;

    logic [2:0][BITS-1:0]      r_s1_pix;
    logic                      r_s1_href;
    logic                      r_s1_vsync;
    logic                      r_s1_de;
    logic [2:0][PROD_W-1:0]    r_s2_prod;
    logic                      r_s2_href;
    logic                      r_s2_vsync;
    logic                      r_s2_de;
    logic [2:0][BITS-1:0]      r_out_pix;
    logic                      r_out_href;
    logic                      r_out_vsync;
    logic                      r_out_de;

    logic [2:0][GAIN_BITS-1:0] r_gain_act;
    logic [2:0][GAIN_BITS-1:0] r_gain_pend;
    logic                      r_pend;

    logic [2:0][SUM_BITS-1:0]  r_acc;
    logic [SUM_BITS-1:0]       r_cnt;
    logic [2:0][SUM_BITS-1:0]  r_stat_sum;
    logic [SUM_BITS-1:0]       r_stat_cnt;
    logic                      r_stat_valid;

    assign w_in_pix  = {in_r, in_g, in_b};
    assign w_gain_in = {gain_r, gain_g, gain_b};

    // r_s1_vsync doubles as the registered vsync for edge detection.
    assign w_fs     = in_vsync & ~r_s1_vsync;
    assign w_pix_ok = in_href & in_de & w_in_win;

    // Round half up, drop the fraction, clamp to full scale.
    function automatic logic [BITS-1:0] f_round_sat(input logic [PROD_W-1:0] prod);
        logic [RND_W-1:0] rnd;
        logic [SHR_W-1:0] shr;
        rnd = RND_W'(prod) + RND_HALF;
        shr = SHR_W'(rnd >> GAIN_FRAC);
        return (shr > PIX_MAX) ? '1 : BITS'(shr);
    endfunction

    // Saturating accumulate: sticks at all-ones instead of wrapping.
    function automatic logic [SUM_BITS-1:0] f_sat_add(input logic [SUM_BITS-1:0] acc,
                                                      input logic [BITS-1:0]     inc);
        logic [ACC_W-1:0] sum;
        sum = ACC_W'(acc) + ACC_W'(inc);
        return sum[SUM_BITS] ? '1 : SUM_BITS'(sum);
    endfunction

    // Pixel pipeline: S1 register, S2 multiply, S3 round/saturate/mask.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_s1_pix    <= '0;
            r_s1_href   <= 1'b0;
            r_s1_vsync  <= 1'b0;
            r_s1_de     <= 1'b0;
            r_s2_prod   <= '0;
            r_s2_href   <= 1'b0;
            r_s2_vsync  <= 1'b0;
            r_s2_de     <= 1'b0;
            r_out_pix   <= '0;
            r_out_href  <= 1'b0;
            r_out_vsync <= 1'b0;
            r_out_de    <= 1'b0;
        end else begin
            r_s1_pix    <= w_in_pix;
            r_s1_href   <= in_href;
            r_s1_vsync  <= in_vsync;
            r_s1_de     <= in_de;
            r_s2_href   <= r_s1_href;
            r_s2_vsync  <= r_s1_vsync;
            r_s2_de     <= r_s1_de;
            r_out_href  <= r_s2_href;
            r_out_vsync <= r_s2_vsync;
            r_out_de    <= r_s2_de;
            for (int c = 0; c < 3; c++) begin
                r_s2_prod[c] <= PROD_W'(r_s1_pix[c]) * PROD_W'(r_gain_act[c]);
                r_out_pix[c] <= r_s2_href ? f_round_sat(r_s2_prod[c]) : '0;
            end
        end
    end

    // Gain shadowing: a write coincident with frame start bypasses the pending copy.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_gain_act  <= {3{GAIN_ONE}};
            r_gain_pend <= {3{GAIN_ONE}};
            r_pend      <= 1'b0;
        end else if (w_fs) begin
            if (gain_wr) begin
                r_gain_act <= w_gain_in;
            end else if (r_pend) begin
                r_gain_act <= r_gain_pend;
            end
            r_pend <= 1'b0;
        end else if (gain_wr) begin
            r_gain_pend <= w_gain_in;
            r_pend      <= 1'b1;
        end
    end

`ifdef AWB_STAT_WINDOW_EN
    logic [15:0] r_col;
    logic [15:0] r_row;
    logic [15:0] r_wx0;
    logic [15:0] r_wx1;
    logic [15:0] r_wy0;
    logic [15:0] r_wy1;
    logic [15:0] w_row;
    logic [15:0] w_wx0;
    logic [15:0] w_wx1;
    logic [15:0] w_wy0;
    logic [15:0] w_wy1;

    // A pixel in the frame-start cycle already belongs to row 0 of the new window.
    assign w_row = w_fs ? 16'd0 : r_row;
    assign w_wx0 = w_fs ? win_x0 : r_wx0;
    assign w_wx1 = w_fs ? win_x1 : r_wx1;
    assign w_wy0 = w_fs ? win_y0 : r_wy0;
    assign w_wy1 = w_fs ? win_y1 : r_wy1;

    assign w_in_win = (r_col >= w_wx0) && (r_col <= w_wx1) &&
                      (w_row >= w_wy0) && (w_row <= w_wy1);

    // Column/row position tracking and window capture.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
            r_wx0 <= '0;
            r_wx1 <= 16'(WIDTH - 1);
            r_wy0 <= '0;
            r_wy1 <= 16'(HEIGHT - 1);
        end else begin
            if (!in_href) begin
                r_col <= '0;
            end else if (in_de) begin
                r_col <= r_col + 16'd1;
            end
            if (w_fs) begin
                r_row <= '0;
                r_wx0 <= win_x0;
                r_wx1 <= win_x1;
                r_wy0 <= win_y0;
                r_wy1 <= win_y1;
            end else if (r_s1_href && !in_href) begin
                r_row <= r_row + 16'd1;
            end
        end
    end
`else
    assign w_in_win = 1'b1;
`endif

    // Frame statistics: publish and restart at frame start.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_stat_sum   <= '0;
            r_stat_cnt   <= '0;
            r_stat_valid <= 1'b0;
        end else begin
            r_stat_valid <= w_fs;
            if (w_fs) begin
                r_stat_sum <= r_acc;
                r_stat_cnt <= r_cnt;
                r_cnt      <= w_pix_ok ? SUM_BITS'(1) : '0;
                for (int c = 0; c < 3; c++) begin
                    r_acc[c] <= w_pix_ok ? SUM_BITS'(w_in_pix[c]) : '0;
                end
            end else if (w_pix_ok) begin
                r_cnt <= f_sat_add(r_cnt, BITS'(1));
                for (int c = 0; c < 3; c++) begin
                    r_acc[c] <= f_sat_add(r_acc[c], w_in_pix[c]);
                end
            end
        end
    end

    assign out_href   = r_out_href;
    assign out_vsync  = r_out_vsync;
    assign out_de     = r_out_de;
    assign out_r      = r_out_pix[2];
    assign out_g      = r_out_pix[1];
    assign out_b      = r_out_pix[0];
    assign stat_sum_r = r_stat_sum[2];
    assign stat_sum_g = r_stat_sum[1];
    assign stat_sum_b = r_stat_sum[0];
    assign stat_cnt   = r_stat_cnt;
    assign stat_valid = r_stat_valid;

endmodule

// File: tb/tb_isp_awb_gain.sv
// Self-checking bench for isp_awb_gain: table-driven gain vectors, hand-written
// shadowing/statistics/reset sequences, and randomized frames checked against
// a cycle-level behavioural model. A second instance with 10-bit accumulators
// exercises statistics saturation.
module tb_isp_awb_gain;

    localparam int GF = 8;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        in_href = 1'b0;
    logic        in_vsync = 1'b0;
    logic        in_de = 1'b0;
    logic [7:0]  in_r = '0;
    logic [7:0]  in_g = '0;
    logic [7:0]  in_b = '0;
    logic [9:0]  gain_r = 10'd256;
    logic [9:0]  gain_g = 10'd256;
    logic [9:0]  gain_b = 10'd256;
    logic        gain_wr = 1'b0;
`ifdef AWB_STAT_WINDOW_EN
    logic [15:0] win_x0 = 16'd0;
    logic [15:0] win_x1 = 16'hFFFF;
    logic [15:0] win_y0 = 16'd0;
    logic [15:0] win_y1 = 16'hFFFF;
`endif

    logic        out_href, out_vsync, out_de;
    logic [7:0]  out_r, out_g, out_b;
    logic [31:0] stat_sum_r, stat_sum_g, stat_sum_b, stat_cnt;
    logic        stat_valid;

    logic        s_href, s_vsync, s_de;
    logic [7:0]  s_r, s_g, s_b;
    logic [9:0]  s_sum_r, s_sum_g, s_sum_b, s_cnt;
    logic        s_valid;

    isp_awb_gain dut (
        .pclk(pclk), .rst(rst),
        .in_href(in_href), .in_vsync(in_vsync), .in_de(in_de),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b), .gain_wr(gain_wr),
`ifdef AWB_STAT_WINDOW_EN
        .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
`endif
        .out_href(out_href), .out_vsync(out_vsync), .out_de(out_de),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .stat_sum_r(stat_sum_r), .stat_sum_g(stat_sum_g), .stat_sum_b(stat_sum_b),
        .stat_cnt(stat_cnt), .stat_valid(stat_valid)
    );

    isp_awb_gain #(.SUM_BITS(10)) dut_s (
        .pclk(pclk), .rst(rst),
        .in_href(in_href), .in_vsync(in_vsync), .in_de(in_de),
        .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .gain_r(gain_r), .gain_g(gain_g), .gain_b(gain_b), .gain_wr(gain_wr),
`ifdef AWB_STAT_WINDOW_EN
        .win_x0(win_x0), .win_x1(win_x1), .win_y0(win_y0), .win_y1(win_y1),
`endif
        .out_href(s_href), .out_vsync(s_vsync), .out_de(s_de),
        .out_r(s_r), .out_g(s_g), .out_b(s_b),
        .stat_sum_r(s_sum_r), .stat_sum_g(s_sum_g), .stat_sum_b(s_sum_b),
        .stat_cnt(s_cnt), .stat_valid(s_valid)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic       href;
        logic       vsync;
        logic       de;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    typedef struct {
        int gr, gg, gb;
        int ir, ig, ib;
        int er, eg, eb;
    } gvec_t;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model state
    pix_t   q_pipe[$];
    int     m_act[3];
    int     m_pnd[3];
    bit     m_pend;
    bit     m_vs_prev;
    longint m_sum[3];
    longint m_cnt;
    longint m_st[3];
    longint m_st_cnt;
    bit     m_st_valid;
    bit     stats_on;

    gvec_t tbl[6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int gp(input int p, input int g);
        int v;
        v = (p * g + (1 << (GF - 1))) >> GF;
        return (v > 255) ? 255 : v;
    endfunction

    function automatic longint satv(input longint v, input int bits);
        longint mx;
        mx = (longint'(1) << bits) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // One clock: update the model for the applied inputs, clock, then compare.
    task automatic step();
        pix_t e;
        bit   fs;
        fs = in_vsync && !m_vs_prev;
        m_vs_prev = in_vsync;
        if (fs) begin
            if (gain_wr) m_act = '{int'(gain_r), int'(gain_g), int'(gain_b)};
            else if (m_pend) m_act = m_pnd;
            m_pend = 1'b0;
        end else if (gain_wr) begin
            m_pnd = '{int'(gain_r), int'(gain_g), int'(gain_b)};
            m_pend = 1'b1;
        end
        e.href  = in_href;
        e.vsync = in_vsync;
        e.de    = in_de;
        e.r     = in_href ? 8'(gp(int'(in_r), m_act[0])) : 8'd0;
        e.g     = in_href ? 8'(gp(int'(in_g), m_act[1])) : 8'd0;
        e.b     = in_href ? 8'(gp(int'(in_b), m_act[2])) : 8'd0;
        q_pipe.push_back(e);
        m_st_valid = fs;
        if (fs) begin
            m_st     = m_sum;
            m_st_cnt = m_cnt;
            m_sum    = '{0, 0, 0};
            m_cnt    = 0;
        end
        if (in_href && in_de) begin
            m_sum[0] += longint'(in_r);
            m_sum[1] += longint'(in_g);
            m_sum[2] += longint'(in_b);
            m_cnt++;
        end
        @(posedge pclk);
        #1;
        e = q_pipe.pop_front();
        check("pipe", {out_href, out_vsync, out_de, out_r, out_g, out_b}, e);
        check("pipe_s", {s_href, s_vsync, s_de, s_r, s_g, s_b}, e);
        if (stats_on) begin
            check("stat", {stat_valid, stat_sum_r, stat_sum_g, stat_sum_b, stat_cnt},
                  {m_st_valid, 32'(satv(m_st[0], 32)), 32'(satv(m_st[1], 32)),
                   32'(satv(m_st[2], 32)), 32'(satv(m_st_cnt, 32))});
            check("stat_sat", {s_valid, s_sum_r, s_sum_g, s_sum_b, s_cnt},
                  {m_st_valid, 10'(satv(m_st[0], 10)), 10'(satv(m_st[1], 10)),
                   10'(satv(m_st[2], 10)), 10'(satv(m_st_cnt, 10))});
        end
    endtask

    task automatic do_reset();
        pix_t z;
        rst = 1'b1;
        @(posedge pclk);
        #1;
        check("reset_out", {out_href, out_vsync, out_de, out_r, out_g, out_b,
                            stat_sum_r, stat_sum_g, stat_sum_b, stat_cnt, stat_valid}, '0);
        check("reset_out_s", {s_href, s_r, s_sum_r, s_sum_g, s_sum_b, s_cnt, s_valid}, '0);
        rst = 1'b0;
        m_act = '{256, 256, 256};
        m_pnd = '{256, 256, 256};
        m_pend = 1'b0;
        m_vs_prev = 1'b0;
        m_sum = '{0, 0, 0};
        m_cnt = 0;
        m_st = '{0, 0, 0};
        m_st_cnt = 0;
        m_st_valid = 1'b0;
        stats_on = 1'b1;
        z = '0;
        q_pipe.delete();
        q_pipe.push_back(z);
        q_pipe.push_back(z);
    endtask

    task automatic px(input int r, input int g, input int b);
        in_href = 1'b1; in_de = 1'b1;
        in_r = 8'(r); in_g = 8'(g); in_b = 8'(b);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_href = 1'b0; in_de = 1'b0;
            in_r = '0; in_g = '0; in_b = '0;
            step();
        end
    endtask

    task automatic vs_rise(input bit wr);
        in_href = 1'b0; in_de = 1'b0;
        in_vsync = 1'b1;
        gain_wr = wr;
        step();
        gain_wr = 1'b0;
        in_vsync = 1'b0;
    endtask

    task automatic set_gains(input int r, input int g, input int b);
        gain_r = 10'(r); gain_g = 10'(g); gain_b = 10'(b);
    endtask

    task automatic frame42(input int r, input int g, input int b);
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 4; p++) px(r, g, b);
            idle(2);
        end
    endtask

    initial begin
        tbl[0] = '{384, 128, 256, 200, 101,  77, 255,  51,  77};
        tbl[1] = '{512, 256,   0,  60, 255, 255, 120, 255,   0};
        tbl[2] = '{1023,  1, 255,   1, 255, 255,   4,   1, 254};
        tbl[3] = '{300, 257, 383,   0, 255, 170,   0, 255, 254};
        tbl[4] = '{128, 128, 128,   1,   3, 255,   1,   2, 128};
        tbl[5] = '{256, 256, 256, 100,  50, 200, 100,  50, 200};

        do_reset();

        // Unity gain after reset, 3-cycle latency, masking when href is low
        px(100, 50, 200);
        idle(1);
        check("latency_not_early", {out_href, out_r}, {1'b0, 8'd0});
        idle(1);
        check("reset_unity", {out_href, out_r, out_g, out_b}, {1'b1, 8'd100, 8'd50, 8'd200});
        idle(1);
        check("href_low_zero", {out_href, out_r, out_g, out_b}, '0);

        // Gain math table; gain_wr coincident with frame start applies at once
        for (int i = 0; i < 6; i++) begin
            set_gains(tbl[i].gr, tbl[i].gg, tbl[i].gb);
            vs_rise(1'b1);
            px(tbl[i].ir, tbl[i].ig, tbl[i].ib);
            idle(2);
            check($sformatf("gain_tbl%0d", i), {out_href, out_r, out_g, out_b},
                  {1'b1, 8'(tbl[i].er), 8'(tbl[i].eg), 8'(tbl[i].eb)});
        end

        // Shadowing: mid-frame write waits for the next frame start
        set_gains(512, 256, 256);
        gain_wr = 1'b1; idle(1); gain_wr = 1'b0;
        px(60, 60, 60); idle(2);
        check("shadow_hold", {out_r, out_g}, {8'd60, 8'd60});
        vs_rise(1'b0);
        px(60, 60, 60); idle(2);
        check("shadow_apply", {out_r, out_g}, {8'd120, 8'd60});
        set_gains(768, 256, 256);
        gain_wr = 1'b1; idle(1); gain_wr = 1'b0;
        set_gains(256, 256, 256);
        gain_wr = 1'b1; idle(1); gain_wr = 1'b0;
        vs_rise(1'b0);
        px(60, 60, 60); idle(2);
        check("shadow_overwrite", out_r, 8'd60);

        // Statistics on a 4x2 frame
        vs_rise(1'b0);
        frame42(10, 20, 30);
        vs_rise(1'b0);
        check("stat_4x2", {stat_valid, stat_sum_r, stat_sum_g, stat_sum_b, stat_cnt},
              {1'b1, 32'd80, 32'd160, 32'd240, 32'd8});
        idle(1);
        check("stat_pulse_once", {stat_valid, stat_sum_r, stat_cnt}, {1'b0, 32'd80, 32'd8});

        // Accumulator saturation on the 10-bit instance
        vs_rise(1'b0);
        frame42(255, 255, 255);
        vs_rise(1'b0);
        check("sat_sum", {s_valid, s_sum_r, s_cnt}, {1'b1, 10'd1023, 10'd8});
        check("nosat_sum", stat_sum_r, 32'd2040);

        // Randomized frames against the model
        for (int f = 0; f < 12; f++) begin
            in_href = ($urandom_range(0, 3) == 0);
            in_de = in_href;
            in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
            gain_wr = ($urandom_range(0, 2) == 0);
            set_gains(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                      int'($urandom_range(0, 1023)));
            in_vsync = 1'b1;
            step();
            gain_wr = 1'b0;
            in_href = 1'b0; in_de = 1'b0;
            in_vsync = ($urandom_range(0, 1) == 1);
            step();
            in_vsync = 1'b0;
            for (int l = 0; l < int'($urandom_range(1, 4)); l++) begin
                for (int p = 0; p < int'($urandom_range(1, 16)); p++) begin
                    in_href = 1'b1;
                    in_de = ($urandom_range(0, 3) != 0);
                    in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
                    gain_wr = ($urandom_range(0, 15) == 0);
                    if (gain_wr)
                        set_gains(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                                  int'($urandom_range(0, 1023)));
                    step();
                    gain_wr = 1'b0;
                end
                for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
                    in_href = 1'b0;
                    in_de = ($urandom_range(0, 1) == 1);
                    in_r = 8'($urandom); in_g = 8'($urandom); in_b = 8'($urandom);
                    step();
                end
            end
        end

        // Mid-frame reset discards partial statistics and restores unity gain
        set_gains(512, 512, 512);
        vs_rise(1'b1);
        px(7, 7, 7);
        px(7, 7, 7);
        in_href = 1'b1; in_de = 1'b1;
        in_r = 8'd9; in_g = 8'd9; in_b = 8'd9;
        do_reset();
        px(60, 5, 5);
        idle(2);
        check("rst_gain_default", {out_href, out_r, out_g}, {1'b1, 8'd60, 8'd5});
        px(5, 5, 5);
        idle(1);
        vs_rise(1'b0);
        check("rst_post_stats", {stat_valid, stat_sum_r, stat_sum_g, stat_sum_b, stat_cnt},
              {1'b1, 32'd65, 32'd10, 32'd10, 32'd2});

`ifdef AWB_STAT_WINDOW_EN
        // Inclusive window, then an inverted window that accumulates nothing
        do_reset();
        stats_on = 1'b0;
        win_x0 = 16'd1; win_x1 = 16'd2; win_y0 = 16'd0; win_y1 = 16'd0;
        vs_rise(1'b0);
        frame42(10, 20, 30);
        win_x0 = 16'd3; win_x1 = 16'd1;
        vs_rise(1'b0);
        check("win_cnt", {stat_cnt, stat_sum_r}, {32'd2, 32'd20});
        frame42(10, 20, 30);
        vs_rise(1'b0);
        check("win_inverted", {stat_cnt, stat_sum_r}, {32'd0, 32'd0});
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/isp_awb_gain.md
Name: isp_awb_gain

Overview:
- Sits directly downstream of the debayer stage and consumes its RGB pixels and href/vsync/de timing.
- Applies per-channel white-balance gains in fixed point, with rounding and saturation, through a 3-stage pipeline.
- Gain updates are shadowed so they take effect only at a frame boundary.
- Accumulates per-frame R/G/B sums and a pixel count from the pre-gain input and presents them at each frame start for firmware AWB.

Parameters:
- BITS, 8, pixel component width.
- GAIN_BITS, 10, unsigned gain width.
- GAIN_FRAC, 8, fractional bits of gain; 1.0 = 256.
- SUM_BITS, 32, width of each statistics accumulator and of the pixel counter.
- WIDTH, 1280, active columns (window feature only).
- HEIGHT, 960, active rows (window feature only).

Ports:
- pclk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_href  in  1  line valid from debayer.
- in_vsync  in  1  frame sync from debayer, active high.
- in_de  in  1  pixel valid from debayer.
- in_r, in_g, in_b  in  BITS each  input pixel.
- gain_r, gain_g, gain_b  in  GAIN_BITS each  requested gains.
- gain_wr  in  1  one-cycle strobe capturing gain_* into the pending registers.
- out_href, out_vsync, out_de  out  1 each  timing delayed by 3 cycles.
- out_r, out_g, out_b  out  BITS each  gained pixel; 0 when out_href=0.
- stat_sum_r, stat_sum_g, stat_sum_b  out  SUM_BITS each  previous-frame sums.
- stat_cnt  out  SUM_BITS  previous-frame count of accumulated pixels.
- stat_valid  out  1  one-cycle pulse when the stat_* outputs update.

Behaviour:
- Reset values:
  - All outputs 0.
  - Active and pending gains = 1<<GAIN_FRAC; pending flag 0.
  - Accumulators and pipeline registers 0.
  - Reset mid-frame discards in-flight pixels and partial statistics; no stat_valid is produced for that frame.
- Pipeline, latency 3 cycles:
  - S1 registers the inputs.
  - S2 forms the product pixel*active_gain, width BITS+GAIN_BITS.
  - S3 adds 1<<(GAIN_FRAC-1), shifts right by GAIN_FRAC, and saturates to 2^BITS-1.
  - href/vsync/de are delayed by exactly 3 registers.
  - out_r/g/b are forced to 0 whenever out_href=0.
- Frame start (fs) is the rising edge of in_vsync, detected against a registered copy of in_vsync.
- Gain shadowing:
  - gain_wr loads pending gains and sets the pending flag; a later gain_wr before fs overwrites them.
  - On fs with the flag set: active gains <= pending and the flag clears.
  - gain_wr in the same cycle as fs: the new gain_* values go directly to active and the flag stays clear.
  - Active gains never change mid-frame.
  - Pixels already in S2/S3 at fs finish with the gains they entered S2 with.
- Statistics:
  - A pixel counts when in_href & in_de.
  - sum_x += in_x (pre-gain) and cnt += 1.
  - Each accumulator saturates at 2^SUM_BITS-1 and holds there; it does not wrap.
  - On fs: stat_* <= accumulators; stat_valid=1 for that single cycle; accumulators and counter clear.
  - A valid pixel in the fs cycle starts the new frame: the accumulator is cleared, then that pixel is added.
  - stat_* hold their values between pulses.
  - The first fs after reset reports whatever was accumulated since reset.

Optional Feature:
- Macro: AWB_STAT_WINDOW_EN.
- When defined:
  - Adds inputs win_x0, win_x1 (16 bits each) and win_y0, win_y1 (16 bits each).
  - An internal column counter resets on in_href low and increments per valid pixel.
  - An internal row counter resets on fs and increments on the in_href falling edge.
  - Only pixels with x0<=col<=x1 and y0<=row<=y1 accumulate; the window is inclusive.
  - Window inputs are sampled at fs.
  - If x0>x1 or y0>y1, nothing accumulates and cnt=0.
- When undefined: the whole frame accumulates, and the counters and ports are absent.
- The gain path is identical in both builds.

Test Plan:
- Reset defaults: BITS=8; in_r/g/b=100/50/200 with href=de=1 -> out 100/50/200 exactly 3 cycles later; out_href aligned; outputs 0 while href low.
- Gain math: gain_wr with r=384, g=128, b=256, then fs; inputs r=200, g=101, b=77 -> out_r=255 (saturated), out_g=51 (50.5 rounds up), out_b=77.
- Shadowing: gain_wr r=512 mid-frame -> output unchanged until after the next fs; then r=60 -> 120. gain_wr coincident with fs -> applies immediately.
- Statistics: 4x2 frame of r/g/b=10/20/30, then fs -> stat_sum 80/160/240, stat_cnt=8, stat_valid high for exactly 1 cycle.
- Accumulator saturation: SUM_BITS=10; 8 pixels of 255 -> stat_sum_r=1023, stat_cnt=8.
- Mid-frame reset: rst for 1 cycle mid-line -> all outputs 0 next cycle; gains back to 256; the next fs reports only post-reset pixels. With AWB_STAT_WINDOW_EN, window (1,2,0,0) on the 4x2 frame -> cnt=2.
